// File: rtl/edge_event_capture_pkg.sv
// Shared types and limits for the edge_event_capture block.
package edge_event_capture_pkg;

  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_t;

  localparam int unsigned EDGE_MAX_CH = 32;

endpackage

// File: rtl/edge_event_capture_chan.sv
// One channel: input sync, optional debounce filter (EDGE_DEBOUNCE_EN), edge detect, sticky status/ovf.
module edge_event_capture_chan
  import edge_event_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       raw,
  input  edge_mode_t mode,
  input  logic       clr,
  output logic       edge_c,
  output logic       status,
  output logic       ovf
);

  logic s;
  logic d;
  logic prev;
  logic rise;
  logic fall;

  // Synchroniser; reset preloads the raw level so no edge follows reset.
  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= {SYNC_STAGES{raw}};
      end else if (clk_en) begin
        sync_q[0] <= raw;
        for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign s = sync_q[SYNC_STAGES-1];
  end else begin : g_nosync
    assign s = raw;
  end

`ifdef EDGE_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  logic             filt;
  logic [CNT_W-1:0] cnt;

  // Filtered level follows s only after DEB_CYCLES consecutive differing ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= raw;
      cnt  <= '0;
    end else if (clk_en) begin
      if (s != filt) begin
        if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
          filt <= s;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
  assign d = filt;
`else
  assign d = s;
`endif

  assign rise = d & ~prev;
  assign fall = ~d & prev;

  always_comb begin
    edge_c = 1'b0;
    unique case (mode)
      EM_RISE: edge_c = rise;
      EM_FALL: edge_c = fall;
      EM_BOTH: edge_c = rise | fall;
      default: edge_c = 1'b0;
    endcase
    edge_c = edge_c & clk_en;
  end

  // prev tracks the detected level regardless of mode, so mode switches never fake an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev   <= raw;
      status <= 1'b0;
      ovf    <= 1'b0;
    end else if (clk_en) begin
      prev <= d;
      if (edge_c)   status <= 1'b1;
      else if (clr) status <= 1'b0;
      if (clr)                  ovf <= 1'b0;
      else if (edge_c && status) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/edge_event_capture.sv
// N-channel edge capture with sticky status, overflow and masked irq.
// Optional debounce filter enabled by defining EDGE_DEBOUNCE_EN.
module edge_event_capture
  import edge_event_capture_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clk_en,
  input  logic [N-1:0]   in,
  input  logic [2*N-1:0] mode,
  input  logic [N-1:0]   mask,
  input  logic [N-1:0]   clr,
  output logic [N-1:0]   edge_c,
  output logic [N-1:0]   status,
  output logic [N-1:0]   ovf,
  output logic           irq
);

  if (N < 1 || N > EDGE_MAX_CH || DEB_CYCLES < 1) begin : g_bad_param
    $error("edge_event_capture: illegal parameter combination");
  end

  for (genvar i = 0; i < int'(N); i++) begin : g_chan
    edge_event_capture_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .raw    (in[i]),
      .mode   (edge_mode_t'(mode[2*i +: 2])),
      .clr    (clr[i]),
      .edge_c (edge_c[i]),
      .status (status[i]),
      .ovf    (ovf[i])
    );
  end

  assign irq = |(status & mask);

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed self-checking bench for edge_event_capture (N=8, SYNC_STAGES=2, DEB_CYCLES=4).
module tb_edge_event_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic [7:0]  in;
  logic [15:0] mode;
  logic [7:0]  mask;
  logic [7:0]  clr;
  logic [7:0]  edge_c;
  logic [7:0]  status;
  logic [7:0]  ovf;
  logic        irq;

  int checks = 0;
  int errors = 0;

  edge_event_capture #(.N(8), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .in     (in),
    .mode   (mode),
    .mask   (mask),
    .clr    (clr),
    .edge_c (edge_c),
    .status (status),
    .ovf    (ovf),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_all();
    clr = 8'hFF;
    tick();
    clr = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; in = 8'h00; mode = 16'h5555; mask = 8'hFF; clr = 8'h00;
    ticks(2);
    reset = 1'b0;
    #1;
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", status); end
    checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL reset_ovf got %h exp 00", ovf); end
    checks++; if (edge_c !== 8'h00) begin errors++; $display("FAIL reset_edge got %h exp 00", edge_c); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
  endtask

  task automatic test_rise_latency();
    mask = 8'h08;
    in[3] = 1'b1;
    tick();
    checks++; if (edge_c !== 8'h00) begin errors++; $display("FAIL rise_early got %h exp 00", edge_c); end
    tick();
    checks++; if (edge_c !== 8'h08) begin errors++; $display("FAIL rise_pulse got %h exp 08", edge_c); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL rise_status_early got %h exp 00", status); end
    tick();
    checks++; if (edge_c !== 8'h00) begin errors++; $display("FAIL rise_one_cycle got %h exp 00", edge_c); end
    checks++; if (status !== 8'h08) begin errors++; $display("FAIL rise_status got %h exp 08", status); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq got %b exp 1", irq); end
    mask = 8'hF7;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_masked got %b exp 0", irq); end
    mask = 8'hFF;
    clr = 8'h08;
    tick();
    clr = 8'h00;
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL rise_clr got %h exp 00", status); end
  endtask

  task automatic test_modes();
    int c0a = 0, c1a = 0, c0b = 0, c1b = 0;
    mode = 16'h555E;
    in[1:0] = 2'b11;
    for (int t = 0; t < 4; t++) begin tick(); c0a += int'(edge_c[0]); c1a += int'(edge_c[1]); end
    in[1:0] = 2'b00;
    for (int t = 0; t < 4; t++) begin tick(); c0b += int'(edge_c[0]); c1b += int'(edge_c[1]); end
    checks++; if (c0a != 0) begin errors++; $display("FAIL mode_fall_on_rise got %0d exp 0", c0a); end
    checks++; if (c1a != 1) begin errors++; $display("FAIL mode_both_rise got %0d exp 1", c1a); end
    checks++; if (c0b != 1) begin errors++; $display("FAIL mode_fall got %0d exp 1", c0b); end
    checks++; if (c1b != 1) begin errors++; $display("FAIL mode_both_fall got %0d exp 1", c1b); end
    checks++; if (status[1:0] !== 2'b11) begin errors++; $display("FAIL mode_status got %b exp 11", status[1:0]); end
    mode = 16'h5555;
    clear_all();
  endtask

  task automatic test_ovf();
    in[2] = 1'b1; ticks(3);
    checks++; if (status !== 8'h04) begin errors++; $display("FAIL ovf_first_set got %h exp 04", status); end
    checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL ovf_none got %h exp 00", ovf); end
    in[2] = 1'b0; ticks(3);
    in[2] = 1'b1; ticks(3);
    checks++; if (ovf !== 8'h04) begin errors++; $display("FAIL ovf_set got %h exp 04", ovf); end
    clr = 8'h04;
    tick();
    clr = 8'h00;
    checks++; if (status[2] !== 1'b0 || ovf[2] !== 1'b0) begin errors++; $display("FAIL ovf_clr got st=%b ovf=%b exp 0 0", status[2], ovf[2]); end
    in[5] = 1'b1; ticks(3);
    in[5] = 1'b0; ticks(3);
    in[5] = 1'b1; ticks(2);
    checks++; if (edge_c !== 8'h20) begin errors++; $display("FAIL ovf_edge5 got %h exp 20", edge_c); end
    clr = 8'h20;
    tick();
    clr = 8'h00;
    checks++; if (status[5] !== 1'b1) begin errors++; $display("FAIL clr_vs_set_status got %b exp 1", status[5]); end
    checks++; if (ovf[5] !== 1'b0) begin errors++; $display("FAIL clr_vs_set_ovf got %b exp 0", ovf[5]); end
    clear_all();
  endtask

  task automatic test_reset_stall();
    int c_low = 0, c0 = 0, c_other = 0;
    in = 8'hFE; ticks(4);
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    checks++; if (edge_c !== 8'h00) begin errors++; $display("FAIL midreset_edge got %h exp 00", edge_c); end
    checks++; if (status !== 8'h00 || ovf !== 8'h00) begin errors++; $display("FAIL midreset_state got st=%h ovf=%h exp 00 00", status, ovf); end
    clk_en = 1'b0;
    in = 8'hFF;
    for (int t = 0; t < 5; t++) begin tick(); if (edge_c !== 8'h00) c_low++; end
    clk_en = 1'b1;
    for (int t = 0; t < 5; t++) begin tick(); c0 += int'(edge_c[0]); if (edge_c[7:1] !== 7'h00) c_other++; end
    checks++; if (c_low != 0) begin errors++; $display("FAIL stall_edge_low got %0d exp 0", c_low); end
    checks++; if (c0 != 1 || c_other != 0) begin errors++; $display("FAIL stall_edge_after got ch0=%0d other=%0d exp 1 0", c0, c_other); end
    checks++; if (status !== 8'h01) begin errors++; $display("FAIL stall_status got %h exp 01", status); end
    clear_all();
  endtask

  task automatic test_mask_off();
    mode = 16'h5455;
    in[4] = 1'b0; ticks(3);
    in[4] = 1'b1; ticks(3);
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL off_no_set got %h exp 00", status); end
    mode = 16'h5555;
    in[4] = 1'b0; ticks(3);
    in[4] = 1'b1; ticks(3);
    checks++; if (status !== 8'h10) begin errors++; $display("FAIL mask_status got %h exp 10", status); end
    mask = 8'h00;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_zero_irq got %b exp 0", irq); end
    mask = 8'h10;
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_set_irq got %b exp 1", irq); end
    mask = 8'hFF;
    clear_all();
  endtask

`ifdef EDGE_DEBOUNCE_EN
  task automatic test_debounce();
    int c_short = 0, t_rise = -1, t_fall = -1, c_tot = 0;
    mode = 16'h7555;
    in[6] = 1'b0; ticks(12);
    clear_all();
    in[6] = 1'b1;
    for (int t = 1; t <= 15; t++) begin tick(); if (t == 3) in[6] = 1'b0; c_short += int'(edge_c[6]); end
    checks++; if (c_short != 0) begin errors++; $display("FAIL deb_short got %0d exp 0", c_short); end
    in[6] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (edge_c[6]) begin
        c_tot++;
        if (t_rise < 0) t_rise = t; else t_fall = t;
      end
      if (t == 6) in[6] = 1'b0;
    end
    checks++; if (t_rise != 6) begin errors++; $display("FAIL deb_rise_time got %0d exp 6", t_rise); end
    checks++; if (t_fall != 12) begin errors++; $display("FAIL deb_fall_time got %0d exp 12", t_fall); end
    checks++; if (c_tot != 2) begin errors++; $display("FAIL deb_count got %0d exp 2", c_tot); end
    mode = 16'h5555;
    clear_all();
  endtask
`endif

  initial begin
    test_reset();
    test_rise_latency();
    test_modes();
    test_ovf();
    test_reset_stall();
    test_mask_off();
`ifdef EDGE_DEBOUNCE_EN
    test_debounce();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
